// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, OCW2 command codes and write-class decode for the PIC command sequencer
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        WC_ICW1    = 2'd0,
        WC_OCW2    = 2'd1,
        WC_OCW3    = 2'd2,
        WC_A0_HIGH = 2'd3
    } wr_class_t;

    localparam logic [2:0] OCW2_NS_EOI        = 3'b001;
    localparam logic [2:0] OCW2_SPEC_EOI      = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS_EOI    = 3'b101;
    localparam logic [2:0] OCW2_SET_ROT_AEOI  = 3'b100;
    localparam logic [2:0] OCW2_CLR_ROT_AEOI  = 3'b000;
    localparam logic [2:0] OCW2_SET_PRIORITY  = 3'b110;

    // A0-low writes are told apart by D4 (ICW1) and then D3 (OCW3 vs OCW2).
    function automatic wr_class_t decode_write(input logic a0, input logic [7:0] d);
        if (a0)
            return WC_A0_HIGH;
        if (d[4])
            return WC_ICW1;
        if (d[3])
            return WC_OCW3;
        return WC_OCW2;
    endfunction

endpackage

// File: rtl/pic_cmd_sequencer.sv
// rtl/pic_cmd_sequencer.sv - ICW1..ICW4 initialization sequencer and OCW1..OCW3 decoder
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter logic [7:0] RESET_IMR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_pulse,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       init_done,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vec_base,
    output logic [7:0] cascade_cfg,
    output logic       aeoi,
    output logic       sfnm,
    output logic [1:0] buf_ms,
    output logic       upm,
    output logic [7:0] imr,
    output logic       ocw2_valid,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_lvl,
    output logic       rot_aeoi,
    output logic       smm,
    output logic       rd_isr,
    output logic       poll_req
);

    seq_state_t state;
    wr_class_t  wclass;

    assign wclass = decode_write(a0, din);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_UNINIT;
            init_done   <= 1'b0;
            ltim        <= 1'b0;
            sngl        <= 1'b0;
            ic4         <= 1'b0;
            vec_base    <= 5'd0;
            cascade_cfg <= 8'd0;
            aeoi        <= 1'b0;
            sfnm        <= 1'b0;
            buf_ms      <= 2'd0;
            upm         <= 1'b0;
            imr         <= RESET_IMR;
            ocw2_valid  <= 1'b0;
            ocw2_cmd    <= 3'd0;
            ocw2_lvl    <= 3'd0;
            rot_aeoi    <= 1'b0;
            smm         <= 1'b0;
            rd_isr      <= 1'b0;
            poll_req    <= 1'b0;
        end else begin
            ocw2_valid <= 1'b0;
            poll_req   <= 1'b0;
            if (wr_pulse) begin
                unique case (wclass)
                    WC_ICW1: begin
                        // vec_base and cascade_cfg survive a restart until rewritten
                        ltim      <= din[3];
                        sngl      <= din[1];
                        ic4       <= din[0];
                        imr       <= RESET_IMR;
                        smm       <= 1'b0;
                        rd_isr    <= 1'b0;
                        rot_aeoi  <= 1'b0;
                        aeoi      <= 1'b0;
                        sfnm      <= 1'b0;
                        buf_ms    <= 2'd0;
                        upm       <= 1'b0;
                        init_done <= 1'b0;
                        state     <= ST_WAIT_ICW2;
                    end
                    WC_A0_HIGH: begin
                        case (state)
                            ST_WAIT_ICW2: begin
                                vec_base <= din[7:3];
                                if (!sngl) begin
                                    state <= ST_WAIT_ICW3;
                                end else if (ic4) begin
                                    state <= ST_WAIT_ICW4;
                                end else begin
                                    state     <= ST_READY;
                                    init_done <= 1'b1;
                                end
                            end
                            ST_WAIT_ICW3: begin
                                cascade_cfg <= din;
                                if (ic4) begin
                                    state <= ST_WAIT_ICW4;
                                end else begin
                                    state     <= ST_READY;
                                    init_done <= 1'b1;
                                end
                            end
                            ST_WAIT_ICW4: begin
                                upm       <= din[0];
                                aeoi      <= din[1];
                                buf_ms    <= din[3:2];
                                sfnm      <= din[4];
                                state     <= ST_READY;
                                init_done <= 1'b1;
                            end
                            ST_READY: imr <= din;
                            default: ;
                        endcase
                    end
                    WC_OCW2: begin
                        if (state == ST_READY) begin
                            ocw2_valid <= 1'b1;
                            ocw2_cmd   <= din[7:5];
                            ocw2_lvl   <= din[2:0];
                            if (din[7:5] == OCW2_SET_ROT_AEOI)
                                rot_aeoi <= 1'b1;
                            else if (din[7:5] == OCW2_CLR_ROT_AEOI)
                                rot_aeoi <= 1'b0;
                        end
                    end
                    WC_OCW3: begin
                        if (state == ST_READY) begin
                            if (din[6])
                                smm <= din[5];
                            if (din[2])
                                poll_req <= 1'b1;
                            if (din[1])
                                rd_isr <= din[0];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb/tb_pic_cmd_sequencer.sv - vector table, directed corners and randomized model check for pic_cmd_sequencer
module tb_pic_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_pulse = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       init_done, ltim, sngl, ic4, aeoi, sfnm, upm;
    logic       ocw2_valid, rot_aeoi, smm, rd_isr, poll_req;
    logic [4:0] vec_base;
    logic [7:0] cascade_cfg, imr;
    logic [1:0] buf_ms;
    logic [2:0] ocw2_cmd, ocw2_lvl;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pic_cmd_sequencer #(.RESET_IMR(8'h00)) dut (
        .clk(clk), .rst(rst), .wr_pulse(wr_pulse), .a0(a0), .din(din),
        .init_done(init_done), .ltim(ltim), .sngl(sngl), .ic4(ic4),
        .vec_base(vec_base), .cascade_cfg(cascade_cfg), .aeoi(aeoi),
        .sfnm(sfnm), .buf_ms(buf_ms), .upm(upm), .imr(imr),
        .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd), .ocw2_lvl(ocw2_lvl),
        .rot_aeoi(rot_aeoi), .smm(smm), .rd_isr(rd_isr), .poll_req(poll_req)
    );

    // Reference model: a queue of the ICWs still owed, filled when ICW1 arrives.
    int         pend[$];
    bit         m_inited;
    logic       m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_upm;
    logic       m_valid, m_rot, m_smm, m_rd, m_poll;
    logic [4:0] m_vec;
    logic [7:0] m_casc, m_imr;
    logic [1:0] m_buf;
    logic [2:0] m_cmd, m_lvl;

    task automatic model_step(input logic r, input logic w, input logic a, input logic [7:0] d);
        if (r) begin
            pend.delete();
            m_inited = 0;
            {m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_upm} = '0;
            {m_valid, m_rot, m_smm, m_rd, m_poll} = '0;
            m_vec = '0; m_casc = '0; m_imr = 8'h00; m_buf = '0; m_cmd = '0; m_lvl = '0;
            return;
        end
        m_valid = 0;
        m_poll = 0;
        if (!w)
            return;
        if (!a && d[4]) begin
            pend.delete();
            pend.push_back(2);
            if (!d[1]) pend.push_back(3);
            if (d[0]) pend.push_back(4);
            m_inited = 0;
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_imr = 8'h00;
            {m_smm, m_rd, m_rot, m_aeoi, m_sfnm, m_upm} = '0;
            m_buf = '0;
        end else if (a) begin
            if (pend.size() > 0) begin
                int k;
                k = pend.pop_front();
                if (k == 2) m_vec = d[7:3];
                else if (k == 3) m_casc = d;
                else begin
                    m_upm = d[0]; m_aeoi = d[1]; m_buf = d[3:2]; m_sfnm = d[4];
                end
                if (pend.size() == 0) m_inited = 1;
            end else if (m_inited) begin
                m_imr = d;
            end
        end else if (m_inited) begin
            if (!d[3]) begin
                m_valid = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
                if (d[7:5] == 3'b100) m_rot = 1;
                if (d[7:5] == 3'b000) m_rot = 0;
            end else begin
                if (d[6]) m_smm = d[5];
                if (d[2]) m_poll = 1;
                if (d[1]) m_rd = d[0];
            end
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {23'd0, init_done, ltim, sngl, ic4, vec_base, cascade_cfg, aeoi, sfnm, buf_ms,
                upm, imr, ocw2_valid, ocw2_cmd, ocw2_lvl, rot_aeoi, smm, rd_isr, poll_req};
    endfunction

    function automatic logic [63:0] model_vec();
        return {23'd0, m_inited, m_ltim, m_sngl, m_ic4, m_vec, m_casc, m_aeoi, m_sfnm, m_buf,
                m_upm, m_imr, m_valid, m_cmd, m_lvl, m_rot, m_smm, m_rd, m_poll};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic a, input logic [7:0] d);
        @(negedge clk);
        rst = r; wr_pulse = w; a0 = a; din = d;
        @(posedge clk);
        model_step(r, w, a, d);
        #1;
    endtask

    typedef struct {
        logic       r, w, a;
        logic [7:0] d;
        logic       e_init;
        logic [7:0] e_imr;
        logic [4:0] e_vec;
        logic [7:0] e_casc;
        logic [5:0] e_misc;   // {ocw2_valid, poll_req, rot_aeoi, smm, rd_isr, aeoi}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic w, input logic a, input logic [7:0] d,
                       input logic ei, input logic [7:0] eimr, input logic [4:0] ev,
                       input logic [7:0] ec, input logic [5:0] em);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d;
        v.e_init = ei; v.e_imr = eimr; v.e_vec = ev; v.e_casc = ec; v.e_misc = em;
        tbl.push_back(v);
    endtask

    initial begin
        add(1, 0, 0, 8'h00, 0, 8'h00, 5'd0, 8'h00, 6'b000000);
        add(0, 0, 0, 8'h00, 0, 8'h00, 5'd0, 8'h00, 6'b000000);
        add(0, 0, 0, 8'h00, 0, 8'h00, 5'd0, 8'h00, 6'b000000);
        add(0, 0, 0, 8'h00, 0, 8'h00, 5'd0, 8'h00, 6'b000000);
        add(0, 1, 0, 8'h13, 0, 8'h00, 5'd0, 8'h00, 6'b000000);
        add(0, 1, 1, 8'h48, 0, 8'h00, 5'd9, 8'h00, 6'b000000);
        add(0, 1, 1, 8'h03, 1, 8'h00, 5'd9, 8'h00, 6'b000001);
        add(0, 1, 0, 8'h11, 0, 8'h00, 5'd9, 8'h00, 6'b000000);
        add(0, 1, 1, 8'h20, 0, 8'h00, 5'd4, 8'h00, 6'b000000);
        add(0, 1, 1, 8'h04, 0, 8'h00, 5'd4, 8'h04, 6'b000000);
        add(0, 1, 1, 8'h01, 1, 8'h00, 5'd4, 8'h04, 6'b000000);
        add(0, 1, 1, 8'hF0, 1, 8'hF0, 5'd4, 8'h04, 6'b000000);
        add(0, 1, 0, 8'h63, 1, 8'hF0, 5'd4, 8'h04, 6'b100000);
        add(0, 0, 0, 8'h00, 1, 8'hF0, 5'd4, 8'h04, 6'b000000);
        add(0, 1, 0, 8'h80, 1, 8'hF0, 5'd4, 8'h04, 6'b101000);
        add(0, 1, 0, 8'h00, 1, 8'hF0, 5'd4, 8'h04, 6'b100000);
        add(0, 1, 0, 8'h6B, 1, 8'hF0, 5'd4, 8'h04, 6'b000110);
        add(0, 1, 0, 8'h0C, 1, 8'hF0, 5'd4, 8'h04, 6'b010110);
        add(0, 0, 0, 8'h00, 1, 8'hF0, 5'd4, 8'h04, 6'b000110);
        add(0, 1, 0, 8'h11, 0, 8'h00, 5'd4, 8'h04, 6'b000000);
        add(0, 1, 1, 8'h28, 0, 8'h00, 5'd5, 8'h04, 6'b000000);
        add(0, 1, 0, 8'h11, 0, 8'h00, 5'd5, 8'h04, 6'b000000);
        add(0, 1, 0, 8'h20, 0, 8'h00, 5'd5, 8'h04, 6'b000000);
        add(0, 1, 1, 8'h30, 0, 8'h00, 5'd6, 8'h04, 6'b000000);
        add(0, 1, 1, 8'h02, 0, 8'h00, 5'd6, 8'h02, 6'b000000);
        add(0, 1, 1, 8'h00, 1, 8'h00, 5'd6, 8'h02, 6'b000000);
        add(1, 1, 1, 8'hAA, 0, 8'h00, 5'd0, 8'h00, 6'b000000);
        add(0, 1, 1, 8'h55, 0, 8'h00, 5'd0, 8'h00, 6'b000000);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("row%0d_init_done", i), 64'(init_done), 64'(tbl[i].e_init));
            check($sformatf("row%0d_imr", i), 64'(imr), 64'(tbl[i].e_imr));
            check($sformatf("row%0d_vec_base", i), 64'(vec_base), 64'(tbl[i].e_vec));
            check($sformatf("row%0d_cascade_cfg", i), 64'(cascade_cfg), 64'(tbl[i].e_casc));
            check($sformatf("row%0d_misc", i),
                  64'({ocw2_valid, poll_req, rot_aeoi, smm, rd_isr, aeoi}), 64'(tbl[i].e_misc));
            check($sformatf("row%0d_model", i), dut_vec(), model_vec());
        end

        // Single-mode init without ICW4, then OCW2 command/level fields and back-to-back pulses.
        step(0, 1, 0, 8'h1A);
        step(0, 1, 1, 8'hF8);
        check("single_no_icw4_ready", 64'({init_done, ltim, sngl, ic4, vec_base}),
              64'({1'b1, 1'b1, 1'b1, 1'b0, 5'h1F}));
        step(0, 1, 0, 8'h63);
        check("ocw2_fields", 64'({ocw2_valid, ocw2_cmd, ocw2_lvl}), 64'({1'b1, 3'b011, 3'd3}));
        step(0, 1, 0, 8'hA5);
        check("ocw2_b2b", 64'({ocw2_valid, ocw2_cmd, ocw2_lvl}), 64'({1'b1, 3'b101, 3'd5}));
        step(0, 1, 0, 8'h0C);
        step(0, 1, 0, 8'h0C);
        check("poll_b2b", 64'({poll_req, ocw2_valid}), 64'({1'b1, 1'b0}));
        step(0, 0, 1, 8'hFF);
        check("pulses_drop", 64'({poll_req, ocw2_valid, imr}), 64'({1'b0, 1'b0, 8'h00}));
        step(0, 1, 0, 8'h11);
        step(0, 1, 1, 8'h08);
        step(0, 1, 1, 8'h80);
        step(0, 1, 1, 8'h1D);
        check("icw4_fields", 64'({init_done, sfnm, buf_ms, aeoi, upm, cascade_cfg}),
              64'({1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h80}));

        for (int n = 0; n < 3000; n++) begin
            logic r, w, a;
            logic [7:0] d;
            r = ($urandom_range(0, 63) == 0);
            w = $urandom_range(0, 1);
            a = $urandom_range(0, 1);
            d = 8'($urandom);
            if (!a && $urandom_range(0, 3) != 0)
                d[4] = 1'b0;
            step(r, w, a, d);
            check($sformatf("rand%0d", n), dut_vec(), model_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
